// File: rtl/scroll_controller_pkg.sv
// Shared types and constants for the scrolling seven-segment message sequencer.
package scroll_controller_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    localparam logic [3:0] BLANK_AN = 4'b1111;
    localparam int         DIGITS   = 4;

    // Active-low one-hot anode select for a digit slot.
    function automatic logic [3:0] anode_sel_n(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/scroll_controller_if.sv
// Control pulses in, display/scroll status out, for the scroll sequencer.
interface scroll_controller_if #(
    parameter int ADDR_W = 4
) ();
    logic              start;
    logic              pause;
    logic              stop;
    logic              step;
    logic [3:0]        an;
    logic [ADDR_W-1:0] char_addr;
    logic [ADDR_W-1:0] base;
    logic              busy;
    logic              scroll_tick;

    modport master (
        output start, pause, stop, step,
        input  an, char_addr, base, busy, scroll_tick
    );

    modport slave (
        input  start, pause, stop, step,
        output an, char_addr, base, busy, scroll_tick
    );
endinterface

// File: rtl/scroll_controller_tick_gen.sv
// Scroll-period counter: pulses once per 2^WIDTH enabled cycles, freezes when disabled.
module scroll_controller_tick_gen #(
    parameter int WIDTH = 23
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    logic [WIDTH-1:0] cnt_r;
    logic             tick_r;

    // Counter and registered pulse; clear beats enable, disabled holds the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r  <= {WIDTH{1'b0}};
            tick_r <= 1'b0;
        end else if (clear) begin
            cnt_r  <= {WIDTH{1'b0}};
            tick_r <= 1'b0;
        end else if (enable) begin
            if (cnt_r == {WIDTH{1'b1}}) begin
                cnt_r  <= {WIDTH{1'b0}};
                tick_r <= 1'b1;
            end else begin
                cnt_r  <= cnt_r + WIDTH'(1);
                tick_r <= 1'b0;
            end
        end else begin
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;
endmodule

// File: rtl/scroll_controller.sv
// Run/pause/stop scroll sequencer with digit multiplexing for a 4-digit display.
module scroll_controller #(
    parameter int TICK_WIDTH    = 23,
    parameter int REFRESH_WIDTH = 16,
    parameter int MSG_LEN       = 16,
    parameter int ADDR_W        = 4
) (
    input logic                 clk,
    input logic                 reset,
    scroll_controller_if.slave  bus
);
    import scroll_controller_pkg::*;

    state_t                   state_r, state_nx_s;
    logic [ADDR_W-1:0]        base_r, base_nx_s, base_inc_s;
    logic [REFRESH_WIDTH-1:0] refresh_r;
    logic [1:0]               digit_r;
    logic [3:0]               an_r;
    logic [ADDR_W-1:0]        char_addr_r, char_mod_s;
    logic [ADDR_W:0]          char_sum_s;
    logic                     busy_r;
    logic                     tick_s, tick_en_s, tick_clr_s;

    // Explicit compare so non-power-of-two message lengths wrap correctly.
    assign base_inc_s = (base_r == ADDR_W'(MSG_LEN - 1)) ? {ADDR_W{1'b0}}
                                                        : base_r + ADDR_W'(1);

    // Next state and base pointer; stop > start > pause > step.
    always_comb begin
        state_nx_s = state_r;
        base_nx_s  = base_r;
        if (bus.stop) begin
            state_nx_s = IDLE;
            base_nx_s  = {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    base_nx_s = {ADDR_W{1'b0}};
                    if (bus.start) state_nx_s = RUN;
                    else           state_nx_s = IDLE;
                end
                RUN: begin
                    if (tick_s) base_nx_s = base_inc_s;
                    else        base_nx_s = base_r;
                    if (bus.start)      state_nx_s = RUN;
                    else if (bus.pause) state_nx_s = PAUSED;
                    else                state_nx_s = RUN;
                end
                PAUSED: begin
                    if (bus.start) begin
                        state_nx_s = RUN;
                        base_nx_s  = base_r;
                    end else if (bus.step) begin
                        state_nx_s = PAUSED;
                        base_nx_s  = base_inc_s;
                    end else begin
                        state_nx_s = PAUSED;
                        base_nx_s  = base_r;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                    base_nx_s  = {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    // The counter only advances on cycles that stay in RUN, so a pause freezes the value it had.
    assign tick_en_s  = (state_r == RUN) && (state_nx_s == RUN);
    assign tick_clr_s = (state_r == IDLE) || bus.stop;

    scroll_controller_tick_gen #(.WIDTH(TICK_WIDTH)) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (tick_en_s),
        .clear  (tick_clr_s),
        .tick   (tick_s)
    );

    // ROM address of the active digit, reduced modulo the message length.
    always_comb begin
        char_sum_s = (ADDR_W + 1)'(base_r) + (ADDR_W + 1)'(digit_r);
        if (char_sum_s >= (ADDR_W + 1)'(MSG_LEN)) begin
            char_mod_s = ADDR_W'(char_sum_s - (ADDR_W + 1)'(MSG_LEN));
        end else begin
            char_mod_s = ADDR_W'(char_sum_s);
        end
    end

    // FSM state, base pointer and busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            base_r  <= {ADDR_W{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            base_r  <= base_nx_s;
            busy_r  <= (state_nx_s != IDLE);
        end
    end

    // Free-running refresh slot counter, digit index and registered display outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refresh_r   <= {REFRESH_WIDTH{1'b0}};
            digit_r     <= 2'd0;
            an_r        <= BLANK_AN;
            char_addr_r <= {ADDR_W{1'b0}};
        end else begin
            refresh_r <= refresh_r + REFRESH_WIDTH'(1);
            if (refresh_r == {REFRESH_WIDTH{1'b1}}) begin
                digit_r <= (digit_r == 2'(DIGITS - 1)) ? 2'd0 : digit_r + 2'd1;
            end else begin
                digit_r <= digit_r;
            end
            // Blank guard slot at the start of every digit period avoids ghosting.
            an_r        <= (refresh_r == {REFRESH_WIDTH{1'b0}}) ? BLANK_AN : anode_sel_n(digit_r);
            char_addr_r <= char_mod_s;
        end
    end

    assign bus.an          = an_r;
    assign bus.char_addr   = char_addr_r;
    assign bus.base        = base_r;
    assign bus.busy        = busy_r;
    assign bus.scroll_tick = tick_s;
endmodule

// File: tb/tb_scroll_controller.sv
// Directed bench for scroll_controller with TICK_WIDTH=3, REFRESH_WIDTH=2, MSG_LEN=6.
module tb_scroll_controller;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    scroll_controller_if #(.ADDR_W(4)) bus ();

    scroll_controller #(
        .TICK_WIDTH    (3),
        .REFRESH_WIDTH (2),
        .MSG_LEN       (6),
        .ADDR_W        (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [3:0] an_seq [6] = '{4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101};
    logic [3:0] ca_seq [6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_tick(input int quiet, input logic [3:0] b0, input logic [3:0] b1);
        for (int i = 0; i < quiet; i++) begin
            cyc();
            chk("tick_quiet", 8'(bus.scroll_tick), 8'd0);
        end
        cyc();
        chk("tick_pulse", 8'(bus.scroll_tick), 8'd1);
        chk("base_at_tick", 8'(bus.base), 8'(b0));
        cyc();
        chk("tick_end", 8'(bus.scroll_tick), 8'd0);
        chk("base_after_tick", 8'(bus.base), 8'(b1));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.stop  = 1'b0;
        bus.step  = 1'b0;

        repeat (3) cyc();
        chk("rst_an", 8'(bus.an), 8'hF);
        chk("rst_base", 8'(bus.base), 8'd0);
        chk("rst_busy", 8'(bus.busy), 8'd0);
        chk("rst_tick", 8'(bus.scroll_tick), 8'd0);
        chk("rst_char", 8'(bus.char_addr), 8'd0);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("an_seq", 8'(bus.an), 8'(an_seq[i]));
        end

        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        chk("start_busy", 8'(bus.busy), 8'd1);
        chk("start_base", 8'(bus.base), 8'd0);
        expect_tick(7, 4'd0, 4'd1);
        expect_tick(6, 4'd1, 4'd2);
        expect_tick(6, 4'd2, 4'd3);
        expect_tick(6, 4'd3, 4'd4);

        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("tick_quiet", 8'(bus.scroll_tick), 8'd0);
            chk("char_addr", 8'(bus.char_addr), 8'(ca_seq[i]));
            if (i == 4) chk("an_guard", 8'(bus.an), 8'hF);
            if (i == 5) chk("an_digit3", 8'(bus.an), 8'h7);
        end
        cyc();
        chk("tick_pulse", 8'(bus.scroll_tick), 8'd1);
        chk("base_at_tick", 8'(bus.base), 8'd4);
        chk("char_d3_b4", 8'(bus.char_addr), 8'd1);
        cyc();
        chk("base_to5", 8'(bus.base), 8'd5);
        expect_tick(6, 4'd5, 4'd0);
        expect_tick(6, 4'd0, 4'd1);

        repeat (2) begin
            cyc();
            chk("tick_quiet", 8'(bus.scroll_tick), 8'd0);
        end
        bus.pause = 1'b1; cyc(); bus.pause = 1'b0;
        chk("pause_busy", 8'(bus.busy), 8'd1);
        repeat (20) begin
            cyc();
            chk("paused_tick", 8'(bus.scroll_tick), 8'd0);
            chk("paused_base", 8'(bus.base), 8'd1);
        end
        bus.step = 1'b1; cyc(); bus.step = 1'b0;
        chk("step1_base", 8'(bus.base), 8'd2);
        bus.step = 1'b1; cyc(); bus.step = 1'b0;
        chk("step2_base", 8'(bus.base), 8'd3);
        chk("step_busy", 8'(bus.busy), 8'd1);
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        expect_tick(4, 4'd3, 4'd4);

        repeat (6) begin
            cyc();
            chk("tick_quiet", 8'(bus.scroll_tick), 8'd0);
        end
        cyc();
        chk("tick_pulse", 8'(bus.scroll_tick), 8'd1);
        chk("base_at_tick", 8'(bus.base), 8'd4);
        bus.pause = 1'b1; cyc(); bus.pause = 1'b0;
        chk("pause_tick_base", 8'(bus.base), 8'd5);
        chk("pause_tick_busy", 8'(bus.busy), 8'd1);
        repeat (12) begin
            cyc();
            chk("paused_tick", 8'(bus.scroll_tick), 8'd0);
            chk("paused_base", 8'(bus.base), 8'd5);
        end
        bus.start = 1'b1; bus.step = 1'b1; cyc(); bus.start = 1'b0; bus.step = 1'b0;
        chk("start_step_base", 8'(bus.base), 8'd5);
        chk("start_step_busy", 8'(bus.busy), 8'd1);
        expect_tick(7, 4'd5, 4'd0);
        expect_tick(6, 4'd0, 4'd1);
        expect_tick(6, 4'd1, 4'd2);
        expect_tick(6, 4'd2, 4'd3);
        expect_tick(6, 4'd3, 4'd4);

        bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
        chk("stop_base", 8'(bus.base), 8'd0);
        chk("stop_busy", 8'(bus.busy), 8'd0);
        chk("stop_tick", 8'(bus.scroll_tick), 8'd0);
        bus.step = 1'b1; cyc(); bus.step = 1'b0;
        chk("idle_step_base", 8'(bus.base), 8'd0);
        bus.pause = 1'b1; cyc(); bus.pause = 1'b0;
        chk("idle_pause_busy", 8'(bus.busy), 8'd0);
        repeat (38) begin
            cyc();
            chk("idle_tick", 8'(bus.scroll_tick), 8'd0);
            chk("idle_base", 8'(bus.base), 8'd0);
            chk("idle_busy", 8'(bus.busy), 8'd0);
        end

        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        chk("restart_busy", 8'(bus.busy), 8'd1);
        expect_tick(7, 4'd0, 4'd1);
        repeat (6) begin
            cyc();
            chk("tick_quiet", 8'(bus.scroll_tick), 8'd0);
        end
        cyc();
        chk("tick_pulse", 8'(bus.scroll_tick), 8'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_tick", 8'(bus.scroll_tick), 8'd0);
        chk("mid_rst_base", 8'(bus.base), 8'd0);
        chk("mid_rst_busy", 8'(bus.busy), 8'd0);
        chk("mid_rst_an", 8'(bus.an), 8'hF);
        chk("mid_rst_char", 8'(bus.char_addr), 8'd0);
        repeat (2) cyc();
        reset = 1'b1;
        repeat (10) begin
            cyc();
            chk("post_rst_tick", 8'(bus.scroll_tick), 8'd0);
            chk("post_rst_busy", 8'(bus.busy), 8'd0);
            chk("post_rst_base", 8'(bus.base), 8'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
